decode_issue_ctrl: RTL and testbench

Sequences instruction delivery into instruction_decoder. Buffers fetched words in a small FIFO and drives the decoder's instruction, n_irdy and n_stall inputs. Enforces FENCE / FENCE.I ordering by draining outstanding memory operations, and raises a trap when the decoder flags a bad instruction. Sits between the fetch unit and the decode stage; one instance per core.

---
 rtl/decode_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: fetch FIFO, fence ordering, FENCE.I flush handshake and bad-instruction trap.
// Optional performance counters are built when DECODE_ISSUE_PERF_EN is defined.
module decode_issue_ctrl #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned OUTST_W = 3
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [31:0] fetch_inst,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   output logic [31:0] dec_inst,
   output logic        n_irdy,
   output logic        n_stall,
   input  logic        exec_stall,
   input  logic        n_bad_inst,
   input  logic        mem_issue,
   input  logic        mem_done,
   output logic        mem_full,
   output logic        icache_flush_req,
   input  logic        icache_flush_ack,
   output logic        refetch,
   output logic        trap_req,
   input  logic        trap_ack,
   input  logic        flush,
   output logic [31:0] perf_issue_cnt,
   output logic [31:0] perf_stall_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [OUTST_W-1:0] CNT_MAX = {OUTST_W{1'b1}};

   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OP_STORE_FP = 7'b0100111;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DRAIN     = 2'd1,
      ST_FLUSH_REQ = 2'd2,
      ST_TRAP      = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         fifo_mem [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OUTST_W-1:0]  cnt_q, cnt_d;
   logic                issued_q;
   logic                flush_req_q, flush_req_d;
   logic                refetch_q, refetch_d;
   logic                trap_req_q, trap_req_d;
   logic                mem_full_q;

   logic                empty, full;
   logic [31:0]         head;
   logic                head_fence, head_fencei, head_memop;
   logic                head_blocked;
   logic                cnt_zero;
   logic                trap_now;
   logic                irdy_c;
   logic                pop_issue;
   logic                fencei_done;
   logic                issue;
   logic                push;

   // FIFO status and head decode
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

   assign head_fence  = (head[6:0] == OP_MISC_MEM) && (head[14:12] == 3'b000);
   assign head_fencei = (head[6:0] == OP_MISC_MEM) && (head[14:12] == 3'b001);
   assign head_memop  = (head[6:0] == OP_LOAD)    || (head[6:0] == OP_STORE) ||
                        (head[6:0] == OP_LOAD_FP) || (head[6:0] == OP_STORE_FP);

   assign cnt_zero = (cnt_q == '0);
   assign trap_now = issued_q & ~n_bad_inst;

   // A fence with outstanding ops, any FENCE.I, or a memory op against a full LSU holds the head
   assign head_blocked = head_fencei | (head_fence & ~cnt_zero) | (mem_full_q & head_memop);

   assign irdy_c = n_rst & ~empty & (state_q == ST_RUN) & ~head_blocked & ~trap_now & ~flush;
   assign n_irdy  = ~irdy_c;
   assign n_stall = ~(exec_stall | (state_q != ST_RUN));

   assign pop_issue   = irdy_c & n_stall;
   assign fencei_done = (state_q == ST_FLUSH_REQ) & flush_req_q & icache_flush_ack &
                        ~trap_now & ~flush;
   assign issue       = pop_issue | fencei_done;

   assign fetch_ready = n_rst & ((state_q == ST_RUN) | (state_q == ST_DRAIN)) &
                        (~full | pop_issue) & ~trap_now & ~flush;
   assign push        = fetch_valid & fetch_ready;

   assign dec_inst         = empty ? 32'h0 : head;
   assign mem_full         = mem_full_q;
   assign icache_flush_req = flush_req_q;
   assign refetch          = refetch_q;
   assign trap_req         = trap_req_q;

   // Outstanding memory-op counter; simultaneous issue and done cancel
   always_comb begin
      cnt_d = cnt_q;
      if (mem_issue && !mem_done && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + OUTST_W'(1);
      end else if (mem_done && !mem_issue && !cnt_zero) begin
         cnt_d = cnt_q - OUTST_W'(1);
      end
   end

   // Next state, FIFO pointers and registered control outputs
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      flush_req_d = flush_req_q;
      refetch_d   = 1'b0;
      trap_req_d  = trap_req_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_issue) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (trap_now) begin
         state_d     = ST_TRAP;
         rd_ptr_d    = wr_ptr_q;
         trap_req_d  = 1'b1;
         flush_req_d = 1'b0;
      end else if (flush) begin
         rd_ptr_d    = wr_ptr_q;
         flush_req_d = 1'b0;
         if (state_q == ST_TRAP) begin
            if (trap_ack) begin
               state_d    = ST_RUN;
               trap_req_d = 1'b0;
            end
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (!empty && head_fencei) begin
                  state_d = ST_FLUSH_REQ;
               end else if (!empty && head_fence && !cnt_zero) begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (cnt_zero) begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH_REQ: begin
               if (flush_req_q) begin
                  if (icache_flush_ack) begin
                     // FENCE.I retires and every younger word is refetched
                     rd_ptr_d    = wr_ptr_q;
                     flush_req_d = 1'b0;
                     refetch_d   = 1'b1;
                     state_d     = ST_RUN;
                  end
               end else if (cnt_zero) begin
                  flush_req_d = 1'b1;
               end
            end
            ST_TRAP: begin
               if (trap_ack) begin
                  trap_req_d = 1'b0;
                  state_d    = ST_RUN;
               end
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= ST_RUN;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         issued_q    <= 1'b0;
         flush_req_q <= 1'b0;
         refetch_q   <= 1'b0;
         trap_req_q  <= 1'b0;
         mem_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         issued_q    <= issue;
         flush_req_q <= flush_req_d;
         refetch_q   <= refetch_d;
         trap_req_q  <= trap_req_d;
         mem_full_q  <= (cnt_d == CNT_MAX);
      end
   end

   // FIFO storage needs no reset; dec_inst is masked while empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= fetch_inst;
      end
   end

`ifdef DECODE_ISSUE_PERF_EN
   logic [31:0] perf_issue_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (issue) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if (!empty && (state_q != ST_TRAP) && !issue) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_issue_cnt = perf_issue_q;
   assign perf_stall_cnt = perf_stall_q;
`else
   assign perf_issue_cnt = 32'h0;
   assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus a randomized run checked by a queue-based scoreboard.
module tb_decode_issue_ctrl;

   localparam int DEPTH   = 4;
   localparam int OUTST_W = 3;
   localparam int MAXCNT  = 7;

   localparam logic [31:0] FENCE_W  = 32'h0FF0000F;
   localparam logic [31:0] FENCEI_W = 32'h0000100F;
   localparam logic [31:0] LOAD_W   = 32'h0000A103;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [31:0] fetch_inst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] dec_inst;
   logic        n_irdy;
   logic        n_stall;
   logic        exec_stall;
   logic        n_bad_inst;
   logic        mem_issue;
   logic        mem_done;
   logic        mem_full;
   logic        icache_flush_req;
   logic        icache_flush_ack;
   logic        refetch;
   logic        trap_req;
   logic        trap_ack;
   logic        flush;
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   int          mcnt;
   bit          mon_en = 1'b0;

   decode_issue_ctrl #(.DEPTH(DEPTH), .OUTST_W(OUTST_W)) dut (
      .clk(clk), .n_rst(n_rst),
      .fetch_inst(fetch_inst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .dec_inst(dec_inst), .n_irdy(n_irdy), .n_stall(n_stall),
      .exec_stall(exec_stall), .n_bad_inst(n_bad_inst),
      .mem_issue(mem_issue), .mem_done(mem_done), .mem_full(mem_full),
      .icache_flush_req(icache_flush_req), .icache_flush_ack(icache_flush_ack),
      .refetch(refetch), .trap_req(trap_req), .trap_ack(trap_ack), .flush(flush),
      .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] alu_w(input int k);
      return 32'h00000013 | (32'(k + 1) << 20);
   endfunction

   function automatic bit is_fence(input logic [31:0] w);
      return (w[6:0] == 7'b0001111) && (w[14:12] == 3'b000);
   endfunction

   function automatic bit is_mem(input logic [31:0] w);
      return (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011) ||
             (w[6:0] == 7'b0000111) || (w[6:0] == 7'b0100111);
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] r;
      int unsigned sel;
      r   = $urandom();
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
         r = FENCE_W;
      end else if (sel == 1) begin
         r[6:0] = 7'b0000011;
      end else if (sel == 2) begin
         r[6:0] = 7'b0100011;
      end else if (sel == 3) begin
         r[6:0] = 7'b0000111;
      end else if (sel == 4) begin
         r[6:0] = 7'b0100111;
      end else begin
         r[6:0] = 7'b0010011;
      end
      return r;
   endfunction

   task automatic set_idle();
      fetch_valid      = 1'b0;
      fetch_inst       = 32'h0;
      exec_stall       = 1'b0;
      n_bad_inst       = 1'b1;
      mem_issue        = 1'b0;
      mem_done         = 1'b0;
      icache_flush_ack = 1'b0;
      trap_ack         = 1'b0;
      flush            = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      set_idle();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Scoreboard monitor: compares every presented head against the model queue
   logic [31:0] mon_h;
   bit          mon_iss;
   always begin
      @(negedge clk);
      #2;
      if (mon_en) begin
         mon_iss = (n_irdy === 1'b0) && (n_stall === 1'b1);
         chk1("mem_full", mem_full, mcnt == MAXCNT);
         if (exp_q.size() == 0) begin
            chk1("idle_irdy", n_irdy, 1'b1);
            chk32("idle_dec", dec_inst, 32'h0);
         end else begin
            mon_h = exp_q[0];
            chk32("head_order", dec_inst, mon_h);
            if (is_fence(mon_h)) begin
               if (mon_iss) chk32("fence_cnt_zero", 32'(mcnt), 32'h0);
            end else begin
               chk1("issue_ready", n_irdy, (mcnt == MAXCNT) && is_mem(mon_h));
               chk1("run_stall", n_stall, !exec_stall);
            end
            if (mon_iss) void'(exp_q.pop_front());
         end
         if (mem_issue && !mem_done && mcnt < MAXCNT) mcnt++;
         else if (mem_done && !mem_issue && mcnt > 0) mcnt--;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   logic [31:0] t4_list [4];
   int pushed, issued;

   initial begin
      // Reset with fetch_valid held high
      n_rst = 1'b0;
      set_idle();
      fetch_valid = 1'b1;
      fetch_inst  = 32'h00500093;
      repeat (3) @(negedge clk);
      #1;
      chk1("rst_fetch_ready", fetch_ready, 1'b0);
      chk1("rst_n_irdy", n_irdy, 1'b1);
      chk1("rst_n_stall", n_stall, 1'b1);
      chk1("rst_trap_req", trap_req, 1'b0);
      chk1("rst_mem_full", mem_full, 1'b0);
      chk1("rst_flush_req", icache_flush_req, 1'b0);
      chk1("rst_refetch", refetch, 1'b0);
      chk32("rst_dec_inst", dec_inst, 32'h0);
      chk32("rst_perf_issue", perf_issue_cnt, 32'h0);
      chk32("rst_perf_stall", perf_stall_cnt, 32'h0);
      @(negedge clk);
      n_rst = 1'b1;
      #1 chk1("first_ready", fetch_ready, 1'b1);
      @(negedge clk);
      fetch_valid = 1'b0;
      #1;
      chk1("first_irdy", n_irdy, 1'b0);
      chk32("first_dec", dec_inst, 32'h00500093);
      @(negedge clk);
      #1 chk1("first_gone", n_irdy, 1'b1);

      // Fill past depth under backpressure, then drain in order
      do_reset();
      exec_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         fetch_valid = 1'b1;
         fetch_inst  = alu_w(k);
         #1 chk1("fill_ready", fetch_ready, k < DEPTH);
         @(negedge clk);
      end
      exec_stall = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         if (j == 0) chk1("full_pop_ready", fetch_ready, 1'b1);
         chk1("drain_irdy", n_irdy, 1'b0);
         chk32("drain_order", dec_inst, alu_w(j));
         @(negedge clk);
         fetch_valid = 1'b0;
      end
      #1 chk1("drain_empty", n_irdy, 1'b1);

      // FENCE waits for outstanding memory ops
      do_reset();
      mem_issue = 1'b1;
      repeat (2) @(negedge clk);
      mem_issue   = 1'b0;
      fetch_valid = 1'b1;
      fetch_inst  = FENCE_W;
      @(negedge clk);
      fetch_valid = 1'b0;
      #1;
      chk1("fence_hold_irdy", n_irdy, 1'b1);
      chk32("fence_head", dec_inst, FENCE_W);
      @(negedge clk);
      mem_done = 1'b1;
      #1;
      chk1("drain_n_stall", n_stall, 1'b0);
      chk1("drain_n_irdy", n_irdy, 1'b1);
      repeat (2) @(negedge clk);
      mem_done = 1'b0;
      #1 chk1("drain_exit_irdy", n_irdy, 1'b1);
      @(negedge clk);
      #1;
      chk1("fence_issue_irdy", n_irdy, 1'b0);
      chk32("fence_issue_dec", dec_inst, FENCE_W);
      @(negedge clk);
      #1 chk1("fence_gone", n_irdy, 1'b1);

      // FENCE.I with two younger words: flush handshake then refetch
      do_reset();
      t4_list[0] = alu_w(20);
      t4_list[1] = FENCEI_W;
      t4_list[2] = alu_w(21);
      t4_list[3] = alu_w(22);
      exec_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fetch_valid = 1'b1;
         fetch_inst  = t4_list[k];
         @(negedge clk);
      end
      fetch_valid = 1'b0;
      exec_stall  = 1'b0;
      #1;
      chk1("fi_older_irdy", n_irdy, 1'b0);
      chk32("fi_older_dec", dec_inst, t4_list[0]);
      @(negedge clk);
      #1;
      chk1("fi_block_irdy", n_irdy, 1'b1);
      chk32("fi_head", dec_inst, FENCEI_W);
      for (int t = 0; t < 20 && !icache_flush_req; t++) @(negedge clk);
      chk1("fi_req_seen", icache_flush_req, 1'b1);
      for (int t = 0; t < 3; t++) begin
         #1 chk1("fi_req_hold", icache_flush_req, 1'b1);
         @(negedge clk);
      end
      icache_flush_ack = 1'b1;
      @(negedge clk);
      icache_flush_ack = 1'b0;
      #1;
      chk1("fi_refetch", refetch, 1'b1);
      chk1("fi_req_drop", icache_flush_req, 1'b0);
      chk1("fi_empty_irdy", n_irdy, 1'b1);
      chk32("fi_empty_dec", dec_inst, 32'h0);
      chk1("fi_run_ready", fetch_ready, 1'b1);
      @(negedge clk);
      #1 chk1("fi_refetch_pulse", refetch, 1'b0);

      // Bad instruction raises a trap and clears the FIFO
      do_reset();
      fetch_valid = 1'b1;
      fetch_inst  = 32'hFFFFFFFF;
      @(negedge clk);
      fetch_inst = alu_w(7);
      #1;
      chk1("trap_issue_irdy", n_irdy, 1'b0);
      chk32("trap_issue_dec", dec_inst, 32'hFFFFFFFF);
      @(negedge clk);
      fetch_valid = 1'b0;
      n_bad_inst  = 1'b0;
      #1 chk1("trap_gate_irdy", n_irdy, 1'b1);
      @(negedge clk);
      n_bad_inst = 1'b1;
      #1;
      chk1("trap_req_set", trap_req, 1'b1);
      chk32("trap_fifo_clr", dec_inst, 32'h0);
      chk1("trap_fetch_ready", fetch_ready, 1'b0);
      @(negedge clk);
      trap_ack = 1'b1;
      #1 chk1("trap_req_hold", trap_req, 1'b1);
      @(negedge clk);
      trap_ack = 1'b0;
      #1;
      chk1("trap_req_clr", trap_req, 1'b0);
      chk1("trap_exit_ready", fetch_ready, 1'b1);

      // Pipeline flush empties the FIFO
      do_reset();
      exec_stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         fetch_valid = 1'b1;
         fetch_inst  = alu_w(30 + k);
         @(negedge clk);
      end
      fetch_valid = 1'b0;
      flush       = 1'b1;
      @(negedge clk);
      flush      = 1'b0;
      exec_stall = 1'b0;
      #1;
      chk1("flush_irdy", n_irdy, 1'b1);
      chk32("flush_dec", dec_inst, 32'h0);

      // Counter saturation and memory-op blocking
      do_reset();
      mem_issue = 1'b1;
      repeat (7) @(negedge clk);
      #1 chk1("mf_set", mem_full, 1'b1);
      fetch_valid = 1'b1;
      fetch_inst  = LOAD_W;
      @(negedge clk);
      fetch_valid = 1'b0;
      mem_issue   = 1'b0;
      #1;
      chk1("mf_sat", mem_full, 1'b1);
      chk1("mf_block", n_irdy, 1'b1);
      @(negedge clk);
      mem_done = 1'b1;
      #1 chk1("mf_block2", n_irdy, 1'b1);
      @(negedge clk);
      mem_done = 1'b0;
      #1;
      chk1("mf_clr", mem_full, 1'b0);
      chk1("mf_load_irdy", n_irdy, 1'b0);
      chk32("mf_load_dec", dec_inst, LOAD_W);

      // Performance counters: 10 issues, 3 stall cycles
      do_reset();
      pushed = 0;
      issued = 0;
      for (int c = 0; c < 40 && issued < 10; c++) begin
         @(negedge clk);
         fetch_valid = (pushed < 10);
         fetch_inst  = alu_w(40 + pushed);
         exec_stall  = (c < 4);
         #1;
         if (fetch_valid && fetch_ready) pushed++;
         if (!n_irdy && n_stall) issued++;
      end
      @(negedge clk);
      fetch_valid = 1'b0;
      exec_stall  = 1'b0;
      #1;
      chk32("perf_issued_seen", 32'(issued), 32'd10);
`ifdef DECODE_ISSUE_PERF_EN
      chk32("perf_issue_cnt", perf_issue_cnt, 32'd10);
      chk32("perf_stall_cnt", perf_stall_cnt, 32'd3);
`else
      chk32("perf_issue_cnt", perf_issue_cnt, 32'd0);
      chk32("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif

      // Randomized traffic against the scoreboard
      do_reset();
      exp_q.delete();
      mcnt   = 0;
      mon_en = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         fetch_valid = ($urandom_range(0, 2) != 0);
         fetch_inst  = rand_word();
         exec_stall  = ($urandom_range(0, 3) == 0);
         mem_issue   = ($urandom_range(0, 2) == 0);
         mem_done    = ($urandom_range(0, 2) == 0);
         #3;
         if (fetch_valid && fetch_ready) begin
            exp_q.push_back(fetch_inst);
            chk1("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
         end
      end
      @(negedge clk);
      fetch_valid = 1'b0;
      exec_stall  = 1'b0;
      mem_issue   = 1'b0;
      mem_done    = 1'b1;
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
      @(negedge clk);
      #3;
      chk32("final_drain", 32'(exp_q.size()), 32'h0);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
